// File: rtl/delay_line_bank.sv
// Bank of CHANNELS recirculating bit-serial word stores sharing one bit-time counter,
// with serial write, word-aligned bank clear and a busy/valid serial-to-parallel capture port.
module delay_line_bank #(
  parameter int WORD_BITS = 28,
  parameter int CHANNELS  = 2,
  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int BW = $clog2(WORD_BITS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RUN,
  input  logic                 WEN,
  input  logic [SW-1:0]        WSEL,
  input  logic                 DIN,
  input  logic [SW-1:0]        RSEL,
  output logic                 DOUT,
  output logic [BW-1:0]        BITCNT,
  output logic                 WORDSTART,
  input  logic                 CLRA,
  output logic                 CLRBUSY,
  input  logic                 CAPREQ,
  input  logic [SW-1:0]        CAPSEL,
  output logic                 CAPBUSY,
  output logic                 CAPVALID,
  output logic [WORD_BITS-1:0] CAPWORD
);

  localparam logic [BW-1:0] LAST = BW'(WORD_BITS - 1);

  typedef enum logic [1:0] {CAP_IDLE, CAP_WAIT, CAP_SHIFT} cap_state_t;

  logic [WORD_BITS-1:0] store [CHANNELS];
  logic [CHANNELS-1:0]  heads;
  logic [CHANNELS-1:0]  tails;
  logic [BW-1:0]        bitcnt;
  logic                 at_start;
  logic                 clr_pend;
  logic                 clr_run;
  logic                 clr_start;
  logic                 clr_act;
  logic                 read_head;
  logic                 cap_head;
  cap_state_t           state_q;
  cap_state_t           state_d;
  logic                 cap_latch;
  logic                 cap_sample;
  logic                 cap_done;
  logic [SW-1:0]        capsel_q;
  logic [WORD_BITS-1:0] capword_q;
  logic                 capvalid_q;

  assign at_start  = (bitcnt == '0);
  // The clear takes effect in the very cycle it starts, ahead of clr_run being registered.
  assign clr_start = RUN && clr_pend && at_start;
  assign clr_act   = clr_start || (RUN && clr_run);

  always_comb begin
    read_head = 1'b0;
    cap_head  = 1'b0;
    heads     = '0;
    tails     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      heads[c] = store[c][0];
      if (WEN && (WSEL == SW'(c)))
        tails[c] = DIN;
      else if (clr_act)
        tails[c] = 1'b0;
      else
        tails[c] = store[c][0];
      if (RSEL == SW'(c))
        read_head = store[c][0];
      if (capsel_q == SW'(c))
        cap_head = store[c][0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int c = 0; c < CHANNELS; c++)
        store[c] <= '0;
    end else if (RUN) begin
      for (int c = 0; c < CHANNELS; c++)
        store[c] <= {tails[c], store[c][WORD_BITS-1:1]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      bitcnt <= '0;
    else if (RUN)
      bitcnt <= (bitcnt == LAST) ? '0 : bitcnt + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      clr_pend <= 1'b0;
      clr_run  <= 1'b0;
    end else begin
      if (clr_start) begin
        clr_pend <= 1'b0;
        clr_run  <= 1'b1;
      end else if (CLRA && !CLRBUSY) begin
        clr_pend <= 1'b1;
      end
      if (RUN && clr_run && (bitcnt == LAST))
        clr_run <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_latch  = 1'b0;
    cap_sample = 1'b0;
    cap_done   = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        if (CAPREQ) begin
          cap_latch = 1'b1;
          state_d   = CAP_WAIT;
        end
      end
      CAP_WAIT: begin
        if (RUN && at_start) begin
          cap_sample = 1'b1;
          state_d    = CAP_SHIFT;
        end
      end
      CAP_SHIFT: begin
        if (RUN) begin
          cap_sample = 1'b1;
          if (bitcnt == LAST) begin
            cap_done = 1'b1;
            state_d  = CAP_IDLE;
          end
        end
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= CAP_IDLE;
      capsel_q   <= '0;
      capword_q  <= '0;
      capvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      capvalid_q <= cap_done;
      if (cap_latch)
        capsel_q <= CAPSEL;
      // Samples the head before this cycle's write/clear replaces it.
      if (cap_sample)
        capword_q[bitcnt] <= cap_head;
    end
  end

  assign DOUT      = read_head;
  assign BITCNT    = bitcnt;
  assign WORDSTART = at_start;
  assign CLRBUSY   = clr_pend | clr_run;
  assign CAPBUSY   = (state_q != CAP_IDLE);
  assign CAPVALID  = capvalid_q;
  assign CAPWORD   = capword_q;

endmodule

// File: tb/tb_delay_line_bank.sv
// Bench for delay_line_bank: directed scenarios plus random traffic, every cycle compared
// against a word-level model (each channel held as a whole word indexed by bit time).
module tb_delay_line_bank;

  localparam int WB = 28;
  localparam int CH = 2;
  localparam int SW = 1;
  localparam int BW = 5;
  localparam logic [WB-1:0] PAT = 28'h0A5C3F1;

  logic CLK = 1'b0;
  logic RST, RUN, WEN, DIN, CLRA, CAPREQ;
  logic [SW-1:0] WSEL, RSEL, CAPSEL;
  logic DOUT, WORDSTART, CLRBUSY, CAPBUSY, CAPVALID;
  logic [BW-1:0] BITCNT;
  logic [WB-1:0] CAPWORD;

  always #5 CLK = ~CLK;

  delay_line_bank #(.WORD_BITS(WB), .CHANNELS(CH)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .WEN(WEN), .WSEL(WSEL), .DIN(DIN),
    .RSEL(RSEL), .DOUT(DOUT), .BITCNT(BITCNT), .WORDSTART(WORDSTART),
    .CLRA(CLRA), .CLRBUSY(CLRBUSY), .CAPREQ(CAPREQ), .CAPSEL(CAPSEL),
    .CAPBUSY(CAPBUSY), .CAPVALID(CAPVALID), .CAPWORD(CAPWORD)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WB-1:0] m [CH];
  int            k;
  bit            clr_pend;
  int            clr_left;
  int            cap_st;      // 0 idle, 1 waiting for word start, 2 collecting bits
  int            cap_sel;
  logic [WB-1:0] cap_word;
  bit            cv;
  bit            synced = 0;

  // Observations from the most recent cycle
  int   cycn = 0;
  int   obs_cyc;
  logic obs_dout, obs_cv, obs_ws;
  logic [BW-1:0] obs_bitcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit run, input bit wen, input int wsel, input bit din,
                     input int rsel, input bit clra, input bit capreq, input int capsel);
    logic [CH-1:0] hd;
    bit busy, clr_now, cv_n;
    logic [31:0] wsel_v, rsel_v, capsel_v;
    wsel_v = wsel; rsel_v = rsel; capsel_v = capsel;
    RST = rst; RUN = run; WEN = wen; WSEL = wsel_v[SW-1:0]; DIN = din;
    RSEL = rsel_v[SW-1:0]; CLRA = clra; CAPREQ = capreq; CAPSEL = capsel_v[SW-1:0];
    #1;
    obs_cyc = cycn; obs_dout = DOUT; obs_cv = CAPVALID; obs_ws = WORDSTART; obs_bitcnt = BITCNT;
    if (synced) begin
      chk("bitcnt",    BITCNT,    k);
      chk("wordstart", WORDSTART, (k == 0));
      chk("dout",      DOUT,      (rsel < CH) ? m[rsel][k] : 1'b0);
      chk("clrbusy",   CLRBUSY,   (clr_pend || clr_left > 0));
      chk("capbusy",   CAPBUSY,   (cap_st != 0));
      chk("capvalid",  CAPVALID,  cv);
      chk("capword",   CAPWORD,   cap_word);
    end
    if (rst) begin
      for (int c = 0; c < CH; c++) m[c] = '0;
      k = 0; clr_pend = 0; clr_left = 0; cap_st = 0; cap_sel = 0; cap_word = '0; cv = 0;
      synced = 1;
    end else begin
      for (int c = 0; c < CH; c++) hd[c] = m[c][k];
      busy = clr_pend || (clr_left > 0);
      if (run && clr_pend && k == 0) begin
        clr_pend = 0;
        clr_left = WB;
      end else if (clra && !busy) begin
        clr_pend = 1;
      end
      clr_now = run && (clr_left > 0);
      cv_n = 0;
      if (cap_st == 0) begin
        if (capreq) begin cap_st = 1; cap_sel = capsel; end
      end else if (cap_st == 1) begin
        if (run && k == 0) cap_st = 2;
      end
      if (cap_st == 2 && run) begin
        cap_word[k] = (cap_sel < CH) ? hd[cap_sel] : 1'b0;
        if (k == WB - 1) begin cap_st = 0; cv_n = 1; end
      end
      cv = cv_n;
      if (run) begin
        for (int c = 0; c < CH; c++)
          m[c][k] = (wen && wsel == c) ? din : (clr_now ? 1'b0 : hd[c]);
        if (clr_now) clr_left--;
        k = (k + 1) % WB;
      end
    end
    cycn++;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input int rsel);
    cyc(0, 1, 0, 0, 0, rsel, 0, 0, 0);
  endtask

  task automatic goto_bit(input int target, input int rsel);
    for (int n = 0; n < WB && k != target; n++) idle(rsel);
  endtask

  task automatic load(input int ch, input logic [WB-1:0] w);
    goto_bit(0, ch);
    for (int i = 0; i < WB; i++) cyc(0, 1, 1, ch, w[i], ch, 0, 0, 0);
  endtask

  task automatic readword(input int ch, output logic [WB-1:0] w);
    goto_bit(0, ch);
    for (int i = 0; i < WB; i++) begin
      idle(ch);
      w[i] = obs_dout;
    end
  endtask

  task automatic wait_valid(output int t);
    t = -1000;
    for (int n = 0; n < 120; n++) begin
      idle(1);
      if (obs_cv === 1'b1) begin t = obs_cyc; break; end
    end
  endtask

  initial begin
    logic [WB-1:0] w, w0;
    int t_req, t_val, ws_cnt, cv_cnt;
    RST = 1; RUN = 0; WEN = 0; WSEL = 0; DIN = 0; RSEL = 0; CLRA = 0; CAPREQ = 0; CAPSEL = 0;
    @(negedge CLK);

    // Reset and free-running count
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_capword", CAPWORD, 0);
    chk("rst_clrbusy", CLRBUSY, 0);
    ws_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      idle(0);
      if (obs_ws === 1'b1) ws_cnt++;
    end
    chk("ws_count", ws_cnt, 3);
    chk("bitcnt_end", obs_bitcnt, 3);

    // Serial write and read back
    load(1, PAT);
    readword(1, w);
    chk("readback_ch1", w, PAT);
    readword(1, w);
    chk("readback_ch1_again", w, PAT);
    readword(0, w);
    chk("readback_ch0", w, 0);

    // Capture requested mid-word
    goto_bit(5, 1);
    t_req = cycn;
    cyc(0, 1, 0, 0, 0, 1, 0, 1, 1);
    chk("capbusy_next", CAPBUSY, 1);
    wait_valid(t_val);
    chk("cap_latency", t_val - t_req, 51);
    chk("cap_word", CAPWORD, PAT);

    // Capture with a RUN stall mid-shift
    goto_bit(5, 1);
    t_req = cycn;
    cyc(0, 1, 0, 0, 0, 1, 0, 1, 1);
    for (int n = 0; n < 60 && !(cap_st == 2 && k == 12); n++) idle(1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 0, 1, 0, 0, 0);
    chk("stall_bitcnt", obs_bitcnt, 12);
    wait_valid(t_val);
    chk("stall_latency", t_val - t_req, 61);
    chk("stall_word", CAPWORD, PAT);

    // Clear overlapping a write
    w0 = 28'($urandom) | 28'h1;
    load(0, w0);
    readword(0, w);
    chk("load_ch0", w, w0);
    goto_bit(9, 0);
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 0);
    chk("clrbusy_set", CLRBUSY, 1);
    goto_bit(3, 0);
    cyc(0, 1, 1, 0, 1, 0, 0, 0, 0);
    chk("clrbusy_active", CLRBUSY, 1);
    goto_bit(0, 0);
    chk("clrbusy_done", CLRBUSY, 0);
    readword(0, w);
    chk("clear_ch0", w, 28'h0000008);
    readword(1, w);
    chk("clear_ch1", w, 0);

    // Reset during capture with a clear pending
    load(1, PAT);
    goto_bit(5, 1);
    cyc(0, 1, 0, 0, 0, 1, 0, 1, 1);
    for (int n = 0; n < 60 && !(cap_st == 2 && k == 10); n++) idle(1);
    cyc(0, 1, 0, 0, 0, 1, 1, 0, 0);
    goto_bit(15, 1);
    chk("pre_rst_capbusy", CAPBUSY, 1);
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 0);
    chk("post_rst_capbusy", CAPBUSY, 0);
    chk("post_rst_capvalid", CAPVALID, 0);
    chk("post_rst_clrbusy", CLRBUSY, 0);
    chk("post_rst_bitcnt", BITCNT, 0);
    cv_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      idle(1);
      if (obs_cv === 1'b1) cv_cnt++;
    end
    chk("no_late_capvalid", cv_cnt, 0);
    readword(1, w);
    chk("post_rst_storage", w, 0);
    goto_bit(5, 1);
    t_req = cycn;
    cyc(0, 1, 0, 0, 0, 1, 0, 1, 1);
    wait_valid(t_val);
    chk("post_rst_cap_latency", t_val - t_req, 51);
    chk("post_rst_cap_word", CAPWORD, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 3),
          $urandom_range(0, CH - 1), $urandom_range(0, 1), $urandom_range(0, CH - 1),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0), $urandom_range(0, CH - 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_line_bank.md
Name: delay_line_bank

Overview:
- Parametrised successor to the fixed accumulator delay line: a bank of CHANNELS recirculating bit-serial word stores, each WORD_BITS long, sharing one bit-time counter.
- Adds per-channel serial write, a word-aligned bank clear, and a serial-to-parallel capture port with a busy/valid handshake.
- Sits between the arithmetic section (serial DIN/DOUT) and the timing/transfer-register logic (word-start strobe, parallel capture).

Parameters:
- WORD_BITS, 28, bits per word per channel (≥2); bits circulate LSB first.
- CHANNELS, 2, number of independent recirculating words (≥1).
- Derived, not overridable: SW = max(1, clog2(CHANNELS)); BW = clog2(WORD_BITS).

Ports:
CLK  in  1  bit-time clock
RST  in  1  synchronous active-high reset
RUN  in  1  advance enable; low freezes the whole block
WEN  in  1  replace recirculating bit of channel WSEL with DIN this bit time
WSEL  in  SW  write channel select
DIN  in  1  serial write data
RSEL  in  SW  serial read channel select
DOUT  out  1  head bit of channel RSEL (combinational from registers)
BITCNT  out  BW  current bit time, 0..WORD_BITS-1
WORDSTART  out  1  high when BITCNT==0
CLRA  in  1  request clear of all channels for one full word
CLRBUSY  out  1  clear pending or active
CAPREQ  in  1  request parallel capture of channel CAPSEL
CAPSEL  in  SW  capture channel select, sampled with CAPREQ
CAPBUSY  out  1  capture in progress
CAPVALID  out  1  one-cycle pulse: CAPWORD updated
CAPWORD  out  WORD_BITS  last captured word

Behaviour:
- Reset (sync, RST=1 at a CLK edge): all channel storage 0, BITCNT 0, CLRBUSY 0, CAPBUSY 0, CAPVALID 0, CAPWORD 0, capture FSM in IDLE. Reset wins over every other input, including mid-capture and mid-clear.
- Storage: each channel is a WORD_BITS shift register. Head = bit 0. At BITCNT=k the head holds word bit k.
- Each RUN=1 cycle, every channel shifts toward the head. The new tail bit is chosen in priority order:
  - DIN, if WEN=1 and WSEL selects the channel;
  - else 0, if the clear is active;
  - else the old head (recirculation).
- Each RUN=1 cycle, BITCNT increments and wraps from WORD_BITS-1 to 0.
- RUN=0: no shift, no count, no capture progress. WEN and DIN are ignored. CLRA and CAPREQ are still accepted.
- WSEL, RSEL or CAPSEL ≥ CHANNELS: write is ignored, DOUT=0, capture returns all-zero.
- Clear:
  - CLRA=1 sets a pending flag.
  - The clear becomes active on the first RUN cycle with BITCNT==0 strictly after the request cycle, and lasts exactly WORD_BITS RUN cycles.
  - CLRBUSY is high from the cycle after CLRA until the cycle after the last cleared bit.
  - CLRA while CLRBUSY=1 is ignored.
- Capture FSM, states IDLE → WAIT → SHIFT → IDLE:
  - IDLE: CAPREQ=1 latches CAPSEL, moves to WAIT, and sets CAPBUSY next cycle.
  - WAIT: on a RUN cycle with BITCNT==0, begin SHIFT in that same cycle, sampling bit 0. The request cycle itself never qualifies, so a request made at BITCNT==0 waits a full word.
  - SHIFT: each RUN cycle stores the pre-write head of the latched channel into CAPWORD[BITCNT].
  - After bit WORD_BITS-1 is sampled, the next cycle pulses CAPVALID for one cycle, drops CAPBUSY, and returns to IDLE.
  - CAPREQ while CAPBUSY=1 is ignored.
  - CAPWORD bits are updated in place during SHIFT. CAPWORD is stable only outside SHIFT and is valid at the CAPVALID pulse.
- Simultaneous events:
  - WEN during an active clear writes DIN (write has priority).
  - A capture overlapping a clear returns the pre-clear heads.
  - A capture overlapping a write returns the old word.

Test Plan:
1. Reset/count: RST 2 cycles, then RUN=1 for 60 cycles → all outputs 0 after reset; BITCNT runs 0..27, 0..27, 0..3; WORDSTART high at cycles 0, 28, 56.
2. Write/readback: WEN=1, WSEL=1, DIN=bits of 28'h0A5C3F1 LSB first from BITCNT=0 for 28 cycles; then RSEL=1 → DOUT reproduces 0x0A5C3F1 LSB first every following word; RSEL=0 → DOUT stays 0.
3. Capture: with the pattern above loaded, CAPREQ=1, CAPSEL=1 at BITCNT=5 → CAPBUSY high 1 cycle later; SHIFT covers BITCNT 0..27 of the next word; CAPVALID pulses 51 cycles after the request; CAPWORD=28'h0A5C3F1.
4. RUN stall: repeat scenario 3 with RUN=0 for 10 cycles at BITCNT=12 during SHIFT → same CAPWORD; CAPVALID 10 cycles later; BITCNT frozen at 12 throughout the stall.
5. Clear with concurrent write: both channels loaded, CLRA at BITCNT=9 → clear runs the next word. During it, WEN=1, WSEL=0, DIN=1 at BITCNT=3 → afterwards channel 0 = 28'h0000008, channel 1 = 0; CLRBUSY low after the word.
6. Reset mid-operation: RST at BITCNT=15 during a SHIFT capture and a pending clear → CAPBUSY, CAPVALID, CLRBUSY all 0 next cycle; storage 0; no late CAPVALID; a new CAPREQ is accepted normally.
